spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
// SPI initiator driving the memory-block wrapper's MOSI/SS_n/MISO link from a parallel request port.
// Converts one WRITE or READ request into two 10-bit SPI frames (2-bit cmd + 8-bit payload).
// For READ, it also captures the 8-bit reply on MISO and returns it on the response port.
// Single clock domain shared with the slave: no SCLK output, one bit per clk cycle.
// PARAMETERS
// GAP_CYCLES  1  SS_n-high cycles between frame 1 and frame 2 (legal 1..15)
// RD_LATENCY  1  cycles after last MOSI bit of read-data frame before first MISO bit (legal 0..15)
// PORTS
// clk        in   1  clock; all state updates on posedge
// rst        in   1  asynchronous, active-high reset
// req_valid  in   1  request present
// req_ready  out  1  high only in IDLE; request accepted on posedge when req_valid&&req_ready
// req_op     in   1  0=WRITE, 1=READ
// req_addr   in   8  memory address
// req_wdata  in   8  write data (ignored for READ)
// rsp_valid  out  1  one-cycle pulse: transaction complete
// rsp_rdata  out  8  read data, valid with rsp_valid; holds last value until overwritten
// MOSI       out  1  serial data to slave, MSB first
// SS_n       out  1  slave select, active low
// MISO       in   1  serial data from slave, MSB first
// BEHAVIOUR
// - Reset (async): SS_n=1, MOSI=0, rsp_valid=0, rsp_rdata=0, req_ready=0 while rst high, state IDLE.
// - FSM: IDLE -> F1 -> GAP -> F2 -> {WRITE: DONE | READ: WAIT -> CAP -> DONE} -> IDLE.
// - Accept at posedge T0: latch op/addr/wdata. Later changes to req_* are ignored.
// - F1, cycles T0+1..T0+10: SS_n=0; MOSI = frame bits 9..0, one per cycle.
//   F1 frame is {2'b00, addr} for WRITE and {2'b10, addr} for READ.
// - GAP, GAP_CYCLES cycles: SS_n=1, MOSI=0.
// - F2, 10 cycles: SS_n=0; frame is {2'b01, wdata} for WRITE and {2'b11, 8'h00} for READ.
// - WRITE: DONE cycle follows F2.
//   At GAP_CYCLES=1: DONE is T0+22, with SS_n=1 and rsp_valid=1 (rsp_rdata unchanged).
// - READ WAIT: SS_n stays 0, MOSI=0, for RD_LATENCY cycles (skipped if 0).
// - READ CAP: 8 cycles, SS_n=0, MOSI=0.
//   MISO is sampled at the posedge ending each CAP cycle, shifted in MSB first.
// - READ DONE: SS_n=1, rsp_valid=1, rsp_rdata=captured byte.
//   At defaults, CAP spans T0+23..T0+30 and DONE is T0+31.
// - req_ready is 0 from the posedge of acceptance through DONE; it returns to 1 the cycle after DONE.
//   A request presented during DONE is not accepted until IDLE.
// - Minimum SS_n-high between transactions: DONE cycle plus the IDLE cycle (2 cycles).
// - MOSI/SS_n are registered outputs, glitch-free; no combinational path from req_* to outputs.
// - Bit counter is 4 bits and wait counter is 4 bits; both reload at each state entry and never wrap mid-state.
// - Address/data 8'hFF pass unchanged; no arithmetic on payloads.
// - rst asserted mid-transaction: SS_n=1 immediately; the transaction is dropped and no rsp_valid is issued.
//   After release, the block is in IDLE with req_ready=1 on the first posedge.
// - MISO is ignored outside CAP.
// TESTING
// 1 WRITE addr=100 data=11 -> MOSI T0+1..10 = 0,0,0110_0100; SS_n=1 at T0+11.
//   MOSI T0+12..21 = 0,1,0000_1011; rsp_valid only at T0+22.
// 2 READ addr=100, behavioural slave drives 8'hA5 in CAP -> F1 = 1,0,0110_0100; F2 = 1,1,0000_0000.
//   SS_n stays low through T0+30; rsp_valid at T0+31 with rsp_rdata=8'hA5.
// 3 Back-to-back: req_valid held high with WRITE then READ -> second accepted exactly 1 cycle after first DONE.
//   req_ready=0 throughout both transactions.
// 4 rst pulse at T0+15 of a WRITE -> SS_n=1 same cycle, no rsp_valid; subsequent WRITE addr=255 data=8'hFF completes normally.
// 5 RD_LATENCY=0, GAP_CYCLES=3 build, READ -> CAP starts the cycle after F2 and DONE at T0+32.
// 6 Against the memory-block wrapper: WRITE addr 100..199 data 11,22,..,253 wrapping to 11.
//   Then READ each address -> every rsp_rdata matches the written value; zero mismatches.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Request/response port and serial link of the SPI initiator.
// The master modport is the controller's view; slave is the requester/target side.
interface spi_master_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       MOSI;
    logic       SS_n;
    logic       MISO;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, MISO,
        output req_ready, rsp_valid, rsp_rdata, MOSI, SS_n
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, MISO,
        input  req_ready, rsp_valid, rsp_rdata, MOSI, SS_n
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI initiator: one WRITE/READ request becomes a command/address frame and a data frame,
// one bit per clk; READ additionally captures the 8-bit reply on MISO.
module spi_master_ctrl #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic          clk,
    input logic          rst,
    spi_master_ctrl_if.master bus
);

    typedef enum logic [2:0] {StIdle, StF1, StGap, StF2, StWait, StCap, StDone} state_t;

    localparam logic [3:0] GapLoad  = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] WaitLoad = 4'(RD_LATENCY - 1);

    state_t      state_q;
    logic        op_q;
    logic [7:0]  wdata_q;
    logic [9:0]  shift_q;
    logic [3:0]  bit_cnt_q;
    logic [3:0]  wait_cnt_q;
    logic [7:0]  cap_q;
    logic        ss_n_q;
    logic        mosi_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rdata_q;
    logic [9:0]  f2_frame;

    assign f2_frame = op_q ? 10'b11_0000_0000 : {2'b01, wdata_q};

    assign bus.SS_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;

    // shift_q always holds the not-yet-sent frame bits left-aligned; mosi_q carries the
    // current bit, so bit_cnt_q counts the bits still to follow in this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 1'b0;
            wdata_q     <= 8'h00;
            shift_q     <= 10'h000;
            bit_cnt_q   <= 4'd0;
            wait_cnt_q  <= 4'd0;
            cap_q       <= 8'h00;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (bus.req_valid && ready_q) begin
                        op_q      <= bus.req_op;
                        wdata_q   <= bus.req_wdata;
                        shift_q   <= {1'b0, bus.req_addr, 1'b0};
                        mosi_q    <= bus.req_op;
                        ss_n_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        bit_cnt_q <= 4'd9;
                        state_q   <= StF1;
                    end
                end
                StF1: begin
                    if (bit_cnt_q == 4'd0) begin
                        ss_n_q     <= 1'b1;
                        mosi_q     <= 1'b0;
                        wait_cnt_q <= GapLoad;
                        state_q    <= StGap;
                    end else begin
                        mosi_q    <= shift_q[9];
                        shift_q   <= {shift_q[8:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q - 4'd1;
                    end
                end
                StGap: begin
                    if (wait_cnt_q == 4'd0) begin
                        ss_n_q    <= 1'b0;
                        mosi_q    <= f2_frame[9];
                        shift_q   <= {f2_frame[8:0], 1'b0};
                        bit_cnt_q <= 4'd9;
                        state_q   <= StF2;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                StF2: begin
                    if (bit_cnt_q == 4'd0) begin
                        mosi_q <= 1'b0;
                        if (!op_q) begin
                            ss_n_q      <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else if (RD_LATENCY == 0) begin
                            bit_cnt_q <= 4'd7;
                            state_q   <= StCap;
                        end else begin
                            wait_cnt_q <= WaitLoad;
                            state_q    <= StWait;
                        end
                    end else begin
                        mosi_q    <= shift_q[9];
                        shift_q   <= {shift_q[8:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q - 4'd1;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 4'd0) begin
                        bit_cnt_q <= 4'd7;
                        state_q   <= StCap;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                StCap: begin
                    cap_q <= {cap_q[6:0], bus.MISO};
                    if (bit_cnt_q == 4'd0) begin
                        rdata_q     <= {cap_q[6:0], bus.MISO};
                        ss_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: scoreboard of requests against responses and MOSI frames,
// with a behavioural memory slave on the default build and a pattern slave on a GAP=3/LAT=0 build.
module tb_spi_master_ctrl;

    typedef struct packed {
        logic       op;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         t0;
    } txn_t;

    typedef struct packed {
        logic [9:0] bits;
        int         len;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    spi_master_ctrl_if bus0 ();
    spi_master_ctrl_if bus1 ();

    spi_master_ctrl dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    spi_master_ctrl #(
        .GAP_CYCLES (3),
        .RD_LATENCY (0)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and slave state for dut0
    txn_t       rsp_q[$];
    frame_t     frm_q[$];
    logic [7:0] exp_mem [256] = '{default: 8'h00};
    logic [7:0] smem [256] = '{default: 8'h00};
    logic [7:0] exp_last = 8'h00;
    logic [7:0] exp_rd;
    logic [7:0] sb;
    txn_t       r;
    frame_t     f;
    int         outstanding = 0;
    int         acc_cnt = 0;
    int         last_done = 0;
    int         mon_len = 0;
    int         pos;
    logic [9:0] mon_bits = 10'h000;
    logic [9:0] s_f1 = 10'h000;
    logic       s_have_f1 = 1'b0;
    logic       b2b = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            rsp_q.delete();
            frm_q.delete();
            outstanding = 0;
            mon_len     = 0;
            s_have_f1   = 1'b0;
            exp_last    = 8'h00;
            bus0.MISO   = 1'b0;
        end else begin
            if (outstanding > 0) check("ready_busy", bus0.req_ready, 0);
            if (bus0.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    r = rsp_q.pop_front();
                    exp_rd = r.op ? exp_mem[r.addr] : exp_last;
                    check("rsp_rdata", bus0.rsp_rdata, exp_rd);
                    check("rsp_cycle", cyc + 1 - r.t0, r.op ? 31 : 22);
                    check("ss_n_done", bus0.SS_n, 1);
                    if (r.op) exp_last = exp_rd;
                    else exp_mem[r.addr] = r.wdata;
                end
                last_done = cyc + 1;
                if (outstanding > 0) outstanding--;
            end
            if (bus0.req_valid && bus0.req_ready) begin
                if (b2b) check("b2b_gap", cyc + 1 - last_done, 1);
                r.op    = bus0.req_op;
                r.addr  = bus0.req_addr;
                r.wdata = bus0.req_wdata;
                r.t0    = cyc + 1;
                rsp_q.push_back(r);
                f.bits = {bus0.req_op, 1'b0, bus0.req_addr};
                f.len  = 10;
                frm_q.push_back(f);
                f.bits = bus0.req_op ? 10'b11_0000_0000 : {2'b01, bus0.req_wdata};
                f.len  = bus0.req_op ? 19 : 10;
                frm_q.push_back(f);
                outstanding++;
                acc_cnt++;
            end
            if (!bus0.SS_n) begin
                pos = mon_len;
                // Reply occupies positions 11..18 of the read-data frame (one wait bit first)
                if (s_have_f1 && s_f1[9:8] == 2'b10 && pos >= 11 && pos <= 18) begin
                    sb = smem[s_f1[7:0]];
                    bus0.MISO = sb[18-pos];
                end else begin
                    bus0.MISO = 1'($urandom_range(0, 1));
                end
                if (pos < 10) mon_bits = {mon_bits[8:0], bus0.MOSI};
                else check("mosi_zero_wait", bus0.MOSI, 0);
                mon_len++;
            end else begin
                bus0.MISO = 1'($urandom_range(0, 1));
                check("mosi_zero_idle", bus0.MOSI, 0);
                if (mon_len > 0) begin
                    if (frm_q.size() == 0) begin
                        check("frame_unexpected", mon_len, 0);
                    end else begin
                        f = frm_q.pop_front();
                        check("frame_bits", mon_bits, f.bits);
                        check("frame_len", mon_len, f.len);
                    end
                    if (!s_have_f1) begin
                        s_f1      = mon_bits;
                        s_have_f1 = 1'b1;
                    end else begin
                        if (s_f1[9:8] == 2'b00 && mon_bits[9:8] == 2'b01 && mon_len == 10)
                            smem[s_f1[7:0]] = mon_bits[7:0];
                        s_have_f1 = 1'b0;
                    end
                    mon_len = 0;
                end
            end
        end
    end

    // Pattern slave for dut1: reply lands on positions 10..17 of the read-data frame
    int         c1_cnt = 0;
    int         c1_t0 = -1;
    int         c1_done = -1;
    logic [7:0] c1_rdata = 8'h00;
    logic [7:0] pat1 = 8'h3C;

    always @(negedge clk) begin
        if (rst1) begin
            c1_cnt    = 0;
            bus1.MISO = 1'b0;
        end else begin
            if (!bus1.SS_n) begin
                if (c1_cnt >= 10 && c1_cnt <= 17) bus1.MISO = pat1[17-c1_cnt];
                else bus1.MISO = 1'($urandom_range(0, 1));
                c1_cnt++;
            end else begin
                bus1.MISO = 1'($urandom_range(0, 1));
                c1_cnt    = 0;
            end
            if (bus1.req_valid && bus1.req_ready) c1_t0 = cyc + 1;
            if (bus1.rsp_valid) begin
                c1_done  = cyc + 1;
                c1_rdata = bus1.rsp_rdata;
            end
        end
    end

    task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] d);
        int target;
        int k;
        b2b            = (outstanding > 0);
        bus0.req_op    = op;
        bus0.req_addr  = a;
        bus0.req_wdata = d;
        bus0.req_valid = 1'b1;
        target = acc_cnt + 1;
        k = 0;
        while (acc_cnt < target && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (acc_cnt < target) check("accept_timeout", acc_cnt, target);
    endtask

    task automatic idle_wait();
        int k;
        k = 0;
        bus0.req_valid = 1'b0;
        while (outstanding > 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (outstanding > 0) check("idle_timeout", outstanding, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        bus0.req_valid = 1'b0;
        bus0.req_op    = 1'b0;
        bus0.req_addr  = 8'h00;
        bus0.req_wdata = 8'h00;
        bus1.req_valid = 1'b0;
        bus1.req_op    = 1'b0;
        bus1.req_addr  = 8'h00;
        bus1.req_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ss_n", bus0.SS_n, 1);
        check("rst_mosi", bus0.MOSI, 0);
        check("rst_rsp_valid", bus0.rsp_valid, 0);
        check("rst_rdata", bus0.rsp_rdata, 0);
        check("rst_ready", bus0.req_ready, 0);
        check("rst_ss_n_b", bus1.SS_n, 1);
        rst  = 1'b0;
        rst1 = 1'b0;
        check("ready_pre_edge", bus0.req_ready, 0);
        @(posedge clk);
        #1;
        check("ready_first_edge", bus0.req_ready, 1);

        // Write/read of one address, then back-to-back write->read
        issue(1'b0, 8'd100, 8'd11);
        issue(1'b0, 8'd100, 8'hA5);
        issue(1'b1, 8'd100, 8'h00);
        idle_wait();
        issue(1'b0, 8'd7, 8'h3A);
        issue(1'b1, 8'd7, 8'h00);
        idle_wait();

        // Reset in the middle of a write's data frame
        issue(1'b0, 8'd50, 8'h77);
        bus0.req_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("ss_low_pre_rst", bus0.SS_n, 0);
        rst = 1'b1;
        #1;
        check("ss_rst_async", bus0.SS_n, 1);
        check("rsp_in_rst", bus0.rsp_valid, 0);
        check("ready_in_rst", bus0.req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_post_rst", bus0.req_ready, 1);
        issue(1'b0, 8'd255, 8'hFF);
        issue(1'b1, 8'd255, 8'h00);
        issue(1'b1, 8'd50, 8'h00);
        idle_wait();

        // Alternate build: gap of 3, no read latency
        bus1.req_op    = 1'b1;
        bus1.req_addr  = 8'h42;
        bus1.req_valid = 1'b1;
        k = 0;
        while (c1_t0 < 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        bus1.req_valid = 1'b0;
        k = 0;
        while (c1_done < 0 && k < 80) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("b_accepted", (c1_t0 >= 0), 1);
        check("b_done_cycle", c1_done - c1_t0, 32);
        check("b_rdata", c1_rdata, 8'h3C);

        // Memory sweep: writes 100..199, then read back
        for (int i = 0; i < 100; i++) issue(1'b0, 8'(100 + i), 8'(11 * ((i % 23) + 1)));
        idle_wait();
        for (int i = 0; i < 100; i++) issue(1'b1, 8'(100 + i), 8'h00);
        idle_wait();

        check("rsp_q_empty", rsp_q.size(), 0);
        check("frm_q_empty", frm_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
